// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and per-op cycle rules for the ALU op sequencer.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd14;
  localparam logic [4:0] OP_NOT  = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic op_is_legal(input logic [4:0] op);
    return (op <= OP_DIV) || (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // Number of EXEC cycles the ALU inputs must be held for this op.
  function automatic int op_cycles(input logic [4:0] op, input int mul_n, input int div_n);
    if (!op_is_legal(op)) return 1;
    if (op == OP_MUL)     return mul_n;
    if (op == OP_DIV)     return div_n;
    return 1;
  endfunction

endpackage

// File: rtl/alu_seq_cnt.sv
// Loadable down-counter with a zero flag; saturates at zero.
module alu_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU op sequencer: accept, hold ALU inputs N cycles, capture, respond.
// Optional ALU_SEQ_STATS_EN adds stat_ops / stat_stall counters.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic [1:0]  rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_select,
  input  logic [31:0] alu_zlow,
  input  logic [63:0] alu_zwide,
  output logic        busy
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [31:0] stat_ops,
  output logic [31:0] stat_stall
`endif
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  state_e      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] lo_q, lo_d, hi_q, hi_d;
  logic [1:0]  err_q, err_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  int               n_cyc;

  alu_seq_cnt #(.W(CNT_W)) u_cnt (
    .clock    (clock),
    .clear    (clear),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    err_d        = err_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    n_cyc        = 1;
    cnt_load_val = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          // Divide-by-zero never needs the ALU, so it short-circuits like an illegal op.
          if (!((req_op == OP_DIV) && (req_b == '0)))
            n_cyc = op_cycles(req_op, MUL_CYCLES, DIV_CYCLES);
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(n_cyc - 1);
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_zero) begin
          if (!op_is_legal(op_q)) begin
            lo_d  = '0;
            hi_d  = '0;
            err_d = 2'b01;
          end else if ((op_q == OP_DIV) && (b_q == '0)) begin
            lo_d  = 32'hFFFF_FFFF;
            hi_d  = a_q;
            err_d = 2'b10;
          end else if ((op_q == OP_MUL) || (op_q == OP_DIV)) begin
            lo_d  = alu_zwide[31:0];
            hi_d  = alu_zwide[63:32];
            err_d = 2'b00;
          end else begin
            lo_d  = alu_zlow;
            hi_d  = '0;
            err_d = 2'b00;
          end
          state_d = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  // req_ready is qualified by clear so every output reads 0 while reset is held.
  assign req_ready  = (state_q == IDLE) && clear;
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_lo     = lo_q;
  assign rsp_hi     = hi_q;
  assign rsp_err    = err_q;
  assign alu_a      = (state_q == EXEC) ? a_q  : '0;
  assign alu_b      = (state_q == EXEC) ? b_q  : '0;
  assign alu_select = (state_q == EXEC) ? op_q : '0;

`ifdef ALU_SEQ_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_ops_d   = stat_ops_q;
    stat_stall_d = stat_stall_q;
    if (state_q == RESP) begin
      if (rsp_ready) stat_ops_d   = stat_ops_q + 32'd1;
      else           stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_ops_q   <= stat_ops_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: behavioural ALU stub, reference model,
// decoupled monitor checking results, latency, ALU hold and handshake rules.
module tb_alu_op_sequencer;

  localparam int MUL_N = 4;
  localparam int DIV_N = 8;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_lo, rsp_hi;
  logic [1:0]  rsp_err;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_select;
  logic [31:0] alu_zlow;
  logic [63:0] alu_zwide;
  logic        busy;
`ifdef ALU_SEQ_STATS_EN
  logic [31:0] stat_ops, stat_stall;
`endif

  alu_op_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clock      (clock),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_lo     (rsp_lo),
    .rsp_hi     (rsp_hi),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_zlow   (alu_zlow),
    .alu_zwide  (alu_zwide),
    .busy       (busy)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU behaviour seen by the sequencer; unused result lanes carry junk.
  function automatic logic [31:0] f_lo(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    logic signed [31:0] sa;
    sh = b[4:0];
    sa = a;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a >> sh;
      5'd5:  return 32'(sa >>> sh);
      5'd6:  return a << sh;
      5'd7:  return (a >> sh) | (a << (6'd32 - {1'b0, sh}));
      5'd8:  return (a << sh) | (a >> (6'd32 - {1'b0, sh}));
      5'd14: return -b;
      5'd15: return ~b;
      default: return 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic logic [63:0] f_wide(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 5'd9) return 64'(sa * sb);
    if (op == 5'd10) begin
      if (b == '0) return 64'hDEAD_BEEF_DEAD_BEEF;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {32'hA5A5_A5A5, f_lo(op, a, b)};
  endfunction

  assign alu_zlow  = f_lo(alu_select, alu_a, alu_b);
  assign alu_zwide = f_wide(alu_select, alu_a, alu_b);

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, lo, hi;
    logic [1:0]  err;
    int          n;
    int          acc;
  } exp_t;

  exp_t sbq[$];

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] w;
    e.op = op; e.a = a; e.b = b; e.acc = 0;
    if (!(op inside {[5'd0:5'd10], 5'd14, 5'd15})) begin
      e.lo = '0; e.hi = '0; e.err = 2'b01; e.n = 1;
    end else if (op == 5'd10 && b == '0) begin
      e.lo = 32'hFFFF_FFFF; e.hi = a; e.err = 2'b10; e.n = 1;
    end else if (op == 5'd9 || op == 5'd10) begin
      w = f_wide(op, a, b);
      e.lo = w[31:0]; e.hi = w[63:32]; e.err = 2'b00;
      e.n = (op == 5'd9) ? MUL_N : DIV_N;
    end else begin
      e.lo = f_lo(op, a, b); e.hi = '0; e.err = 2'b00; e.n = 1;
    end
    return e;
  endfunction

  // Response-ready driver: optional forced stall count, else random or always-ready.
  int bp_left = 0;
  bit rr_rand = 1'b0;
  initial forever begin
    @(posedge clock);
    #1;
    if (rsp_valid && bp_left > 0) begin
      rsp_ready = 1'b0;
      bp_left--;
    end else if (rr_rand) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      rsp_ready = 1'b1;
    end
  end

  // Monitor
  bit          in_resp = 1'b0;
  logic [63:0] held_lohi;
  logic [1:0]  held_err;
  logic [31:0] last_lo = '0, last_hi = '0;
  logic [1:0]  last_err = '0;
  int          hs_cnt = 0;

  initial forever begin
    @(negedge clock);
    if (clear) begin
      if (rsp_valid) begin
        chk("resp_busy", 64'(busy), 64'd1);
        chk("resp_req_ready", 64'(req_ready), 64'd0);
        chk("resp_alu_ab", {alu_a, alu_b}, 64'd0);
        chk("resp_alu_sel", 64'(alu_select), 64'd0);
        if (!in_resp) begin
          if (sbq.size() == 0) begin
            chk("unexpected_rsp", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            $display("[TB] op=%02h a=%h b=%h -> lo=%h hi=%h err=%b lat=%0d",
                     e.op, e.a, e.b, rsp_lo, rsp_hi, rsp_err, cyc - e.acc);
            chk("rsp_lo", 64'(rsp_lo), 64'(e.lo));
            chk("rsp_hi", 64'(rsp_hi), 64'(e.hi));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("latency", 64'(cyc - e.acc), 64'(e.n));
          end
          last_lo = rsp_lo; last_hi = rsp_hi; last_err = rsp_err;
          held_lohi = {rsp_lo, rsp_hi};
          held_err = rsp_err;
          in_resp = 1'b1;
        end else begin
          chk("rsp_hold_lohi", {rsp_lo, rsp_hi}, held_lohi);
          chk("rsp_hold_err", 64'(rsp_err), 64'(held_err));
        end
        if (rsp_ready) begin
          in_resp = 1'b0;
          hs_cnt++;
        end
      end else begin
        if (in_resp) begin
          chk("rsp_dropped", 64'd1, 64'd0);
          in_resp = 1'b0;
        end
        if (sbq.size() > 0) begin
          chk("exec_busy", 64'(busy), 64'd1);
          chk("exec_req_ready", 64'(req_ready), 64'd0);
          chk("exec_alu_ab", {alu_a, alu_b}, {sbq[0].a, sbq[0].b});
          chk("exec_alu_sel", 64'(alu_select), 64'(sbq[0].op));
        end else begin
          chk("idle_busy", 64'(busy), 64'd0);
          chk("idle_req_ready", 64'(req_ready), 64'd1);
          chk("idle_alu_ab", {alu_a, alu_b}, 64'd0);
          chk("idle_alu_sel", 64'(alu_select), 64'd0);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clock);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    while (!req_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    e = model(op, a, b);
    e.acc = cyc + 1;
    @(posedge clock);
    sbq.push_back(e);
    #1;
    req_valid = 1'b0;
    req_op = 5'($urandom);
    req_a  = $urandom;
    req_b  = $urandom;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sbq.size() != 0 || rsp_valid) && w < 500) begin
      @(negedge clock);
      w++;
    end
    if (w >= 500) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic chk_last(input string name, input logic [31:0] lo, input logic [31:0] hi, input logic [1:0] err);
    chk({name, "_lo"}, 64'(last_lo), 64'(lo));
    chk({name, "_hi"}, 64'(last_hi), 64'(hi));
    chk({name, "_err"}, 64'(last_err), 64'(err));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({name, "_rsp_lohi"}, {rsp_lo, rsp_hi}, 64'd0);
    chk({name, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({name, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
    chk({name, "_alu_sel"}, 64'(alu_select), 64'd0);
  endtask

  task automatic pulse_clear();
    #2;
    clear = 1'b0;
    #1;
    check_reset_outputs("clear");
    sbq.delete();
    in_resp = 1'b0;
    hs_cnt = 0;
    @(negedge clock);
    @(negedge clock);
    #2;
    clear = 1'b1;
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    #1 clear = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(negedge clock);
    #2 clear = 1'b1;
    #1 chk("reset_release_req_ready", 64'(req_ready), 64'd1);

    rr_rand = 1'b0;
    issue(5'd0, 32'd5, 32'd7);             wait_idle(); chk_last("add", 32'd12, 32'd0, 2'b00);
    issue(5'd9, 32'hFFFF_FFFF, 32'd2);     wait_idle(); chk_last("mul", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b00);
    issue(5'd10, 32'd17, 32'd5);           wait_idle(); chk_last("div", 32'd3, 32'd2, 2'b00);
    issue(5'd10, 32'd9, 32'd0);            wait_idle(); chk_last("div0", 32'hFFFF_FFFF, 32'd9, 2'b10);
    issue(5'b10000, 32'd1, 32'd2);         wait_idle(); chk_last("illegal", 32'd0, 32'd0, 2'b01);
    issue(5'd0, 32'd1, 32'd1);             wait_idle(); chk_last("add_after_ill", 32'd2, 32'd0, 2'b00);

    bp_left = 3;
    issue(5'd0, 32'd10, 32'd20);           wait_idle(); chk_last("backpressure", 32'd30, 32'd0, 2'b00);

    issue(5'd9, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clock);
    pulse_clear();
    repeat (12) @(negedge clock);
    issue(5'd0, 32'd3, 32'd4);             wait_idle(); chk_last("add_after_clear", 32'd7, 32'd0, 2'b00);

    rr_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2)      op = 5'd9;
      else if (r < 4) op = 5'd10;
      else            op = 5'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      issue(op, a, b);
    end
    wait_idle();

`ifdef ALU_SEQ_STATS_EN
    @(negedge clock);
    chk("stat_ops", 64'(stat_ops), 64'(hs_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle controller that owns the shared 32-bit ALU datapath (add/sub/logic/shift/rotate/MUL/DIV/NOT). It accepts one operation per valid/ready request and registers operands. It holds ALU inputs and select stable for an op-dependent number of cycles, so Booth MUL and DIV meet timing as multicycle paths. It then captures the low/wide results into HI/LO result registers and returns them on a valid/ready response channel. It sits between the control unit and the ALU.

Parameters:
MUL_CYCLES, 4, EXEC cycles held for MUL (min 1)
DIV_CYCLES, 8, EXEC cycles held for DIV (min 1)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  5  ALU select code
req_a  in  32  operand A (Y side)
req_b  in  32  operand B (bus side)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_lo  out  32  result low word / quotient
rsp_hi  out  32  product high word / remainder; 0 for single-word ops
rsp_err  out  2  bit0 illegal opcode, bit1 divide-by-zero
alu_a  out  32  to ALU A
alu_b  out  32  to ALU B
alu_select  out  5  to ALU select
alu_zlow  in  32  from ALU Zlow
alu_zwide  in  64  from ALU Zwide
busy  out  1  high in any state except IDLE

Behaviour:
- Legal ops: 00000–01010, 01110, 01111. MUL=01001, DIV=01010. All others are illegal.
- States: IDLE, EXEC, RESP.
- Reset (clear low, async): state=IDLE, counter=0, operand/result regs=0. req_ready=1 once clear deasserts. rsp_valid=0, rsp_lo/hi/err=0, alu_a/b/select=0, busy=0. An in-flight op is discarded with no response.
- IDLE: req_ready=1. On req_valid&&req_ready edge: latch op/A/B, load counter with N-1, go to EXEC.
  - N=MUL_CYCLES for MUL, DIV_CYCLES for DIV, 1 otherwise.
  - Illegal op or DIV with B==0: N=1 (short-circuit).
- EXEC: req_ready=0. alu_a/alu_b/alu_select driven from latched regs, constant for the whole state. Counter decrements each cycle. At the edge where counter==0:
  - Capture into result regs, then go to RESP.
  - MUL/DIV: lo=alu_zwide[31:0], hi=alu_zwide[63:32].
  - Other legal ops: lo=alu_zlow, hi=0.
  - Illegal op: lo=hi=0, err=01.
  - DIV by zero: lo=32'hFFFFFFFF, hi=A, err=10; the ALU result is ignored.
- RESP: rsp_valid=1; rsp_* held stable while rsp_ready=0. On rsp_ready edge: rsp_valid drops, go to IDLE. No accept in the same cycle.
- Latency: rsp_valid rises N edges after the accept edge. Throughput is one op per N+2 cycles minimum.
- IDLE/RESP: alu_a/b/select=0.
- req_* changing outside the accept edge has no effect.
- Unsigned-to-signed interpretation is the ALU's concern; the sequencer never alters operands.

Optional Feature:
ALU_SEQ_STATS_EN
- Defined: adds output ports stat_ops[31:0] and stat_stall[31:0], both reset to 0 by clear.
  - stat_ops increments on each response handshake.
  - stat_stall increments each cycle in RESP with rsp_ready=0.
  - Both wrap at 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams (OP_ADD…OP_NOT, OP_MUL, OP_DIV)
  - state enum {IDLE, EXEC, RESP}
  - function op_is_legal(op)
  - function op_cycles(op) returning N
- One sub-module, alu_seq_cnt: loadable down-counter with a zero flag, sized $clog2(max(MUL_CYCLES, DIV_CYCLES))+1.

Test Plan:
- ADD, A=5, B=7, rsp_ready=1 -> alu_select=00000 for 1 cycle; rsp_valid 1 edge after accept; rsp_lo=12, rsp_hi=0, rsp_err=0.
- MUL, A=32'hFFFFFFFF, B=2 -> alu_* stable for 4 cycles; rsp_lo=32'hFFFFFFFE, rsp_hi=32'hFFFFFFFF after 4 edges.
- DIV 17/5 -> rsp_lo=3, rsp_hi=2 after 8 edges. DIV 9/0 -> 1 edge; rsp_lo=32'hFFFFFFFF, rsp_hi=9, rsp_err=10.
- Illegal op 5'b10000 -> 1 edge; rsp_lo=rsp_hi=0, rsp_err=01. Follow-up ADD 1+1 returns 2 with err=0.
- Backpressure: rsp_ready low 3 cycles after rsp_valid -> outputs held, req_ready=0, busy=1. Response consumed on 4th cycle; req_ready=1 next cycle.
- clear pulsed low during MUL EXEC cycle 2 -> all outputs 0 immediately; no rsp_valid afterward. New ADD 3+4 returns 7.
